wb_result_stage: RTL and testbench
==================================

Name: wb_result_stage

Overview:
Parametrised successor to the single-cycle writeback result mux, used by the pipelined core.
- Selects one of NUM_SRC result sources and applies RV32I load sign/zero extension to the load-data source.
- Registers the selected result together with rd/RegWrite into a 2-entry skid buffer with valid/ready handshakes.
- Sits between the MEM stage and the register file write port.

Parameters:
XLEN, 32, datapath width (power of 2, >= 32)
NUM_SRC, 4, number of result sources (>= 2); index 0 ALUResult, 1 ReadData, 2 PCPlus4, 3 ImmExt
SEL_W, $clog2(NUM_SRC), width of the source select
LOAD_SRC, 1, source index that receives load extension

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of buffered entries
in_valid  in  1  MEM-stage entry valid
in_ready  out  1  stage can accept an entry
src_data  in  NUM_SRC*XLEN  packed sources; source i occupies bits [i*XLEN +: XLEN]
result_src  in  SEL_W  source select
funct3  in  3  load type
addr_lsb  in  2  byte offset of the load address
rd_in  in  5  destination register
reg_write_in  in  1  write enable
out_valid  out  1  buffered head entry valid
out_ready  in  1  register-file side accepts head
result  out  XLEN  head result (signed)
rd_out  out  5  head rd
reg_write_out  out  1  head write enable, gated by out_valid

Behaviour:
- Reset (async, rst=1):
  - state=EMPTY; out_valid=0, result=0, rd_out=0, reg_write_out=0.
  - in_ready=1 immediately on reset release.
- Select (combinational, before the buffer):
  - result_src < NUM_SRC: pick src_data[result_src].
  - result_src >= NUM_SRC: 0 (matches the legacy default).
- Load extension applies only when result_src == LOAD_SRC. The selected lane is data >> (8*addr_lsb).
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend halfword; addr_lsb[0] ignored, lane = addr_lsb[1].
  - 010 LW: pass through.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
  - Any other funct3: pass through unchanged.
- Buffer: 2 entries (head, skid). States EMPTY, ONE, FULL.
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (state != FULL), driven from a register, with no combinational path from out_ready.
  - out_valid = (state != EMPTY).
  - EMPTY: push -> ONE; the entry appears on outputs the next cycle (latency 1).
  - ONE: push & !pop -> FULL (entry to skid). pop & !push -> EMPTY. push & pop -> ONE (head replaced by new entry).
  - FULL: pop -> ONE (skid moves to head). No push is possible.
- Output hold: head outputs stay stable while out_valid=1 & out_ready=0.
- reg_write_out = head reg_write & out_valid.
- rd = 0 entries pass through unchanged; suppressing x0 writes is the register file's job.
- Flush:
  - Next state is EMPTY and pending entries are discarded; result/rd hold their last values, but out_valid=0 and reg_write_out=0.
  - Flush overrides a simultaneous push.
- rst during activity: takes effect immediately, and all entries are lost.
- No arithmetic beyond extension. Widths are fixed by XLEN, with no truncation.

Test Plan:
1. Reset: rst=1 mid-stream with FULL buffer -> out_valid=0, result=0, reg_write_out=0 asynchronously; after release in_ready=1.
2. Select: push result_src=0..3 with src_data = 0x11111111, 0x22222222, 0x33333333, 0x44444444, out_ready=1 -> result matches each source one cycle later. result_src=3 with NUM_SRC=3 -> result=0.
3. Load extension: ReadData=0x80F17F85, result_src=1:
   - LB addr_lsb=0 -> 0xFFFFFF85
   - LBU addr_lsb=3 -> 0x00000080
   - LH addr_lsb=2 -> 0xFFFF80F1
   - LHU addr_lsb=0 -> 0x00007F85
   - LW -> 0x80F17F85
   - funct3=011 -> 0x80F17F85
4. Backpressure: out_ready=0, push A then B -> state FULL, in_ready=0, head holds A. Then out_ready=1 -> A popped, B output next, then EMPTY. No loss or duplication over a 1000-entry random valid/ready stream checked against a scoreboard.
5. Simultaneous push/pop in ONE: head A, push B with out_ready=1 -> next cycle head=B, state ONE, in_ready=1.
6. Flush: FULL buffer, flush=1 with in_valid=1 -> next cycle out_valid=0, reg_write_out=0, in_ready=1, and the pushed entry is not delivered.

Source files
------------

// File: rtl/wb_result_stage.sv
// Writeback result stage: source select, RV32I load extension and a 2-entry
// skid buffer feeding the register-file write port.
module wb_result_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_SRC  = 4,
  parameter int unsigned SEL_W    = $clog2(NUM_SRC),
  parameter int unsigned LOAD_SRC = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  input  logic [SEL_W-1:0]        result_src,
  input  logic [2:0]              funct3,
  input  logic [1:0]              addr_lsb,
  input  logic [4:0]              rd_in,
  input  logic                    reg_write_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         result,
  output logic [4:0]              rd_out,
  output logic                    reg_write_out
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic [4:0]      rd;
    logic            rw;
  } entry_t;

  state_e          state_q, state_d;
  entry_t          head_q, head_d;
  entry_t          skid_q, skid_d;
  entry_t          new_entry;
  logic [XLEN-1:0] sel_data;
  logic [XLEN-1:0] ext_data;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic            push, pop;

  // Source mux; out-of-range selects yield zero like the legacy mux.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (result_src == SEL_W'(i)) sel_data = src_data[i*XLEN +: XLEN];
    end
  end

  // Halfword lane uses only addr_lsb[1]; misaligned halfwords are not split.
  assign byte_v = 8'(sel_data >> {addr_lsb, 3'b000});
  assign half_v = 16'(sel_data >> {addr_lsb[1], 4'b0000});

  // Load extension, only on the load-data source.
  always_comb begin
    ext_data = sel_data;
    if (result_src == SEL_W'(LOAD_SRC)) begin
      case (funct3)
        3'b000:  ext_data = {{(XLEN-8){byte_v[7]}}, byte_v};
        3'b001:  ext_data = {{(XLEN-16){half_v[15]}}, half_v};
        3'b100:  ext_data = {{(XLEN-8){1'b0}}, byte_v};
        3'b101:  ext_data = {{(XLEN-16){1'b0}}, half_v};
        default: ext_data = sel_data;
      endcase
    end
  end

  assign new_entry = '{res: ext_data, rd: rd_in, rw: reg_write_in};

  // Ready depends only on registered state, never on out_ready.
  assign in_ready      = (state_q != StFull);
  assign out_valid     = (state_q != StEmpty);
  assign push          = in_valid & in_ready;
  assign pop           = out_valid & out_ready;
  assign result        = head_q.res;
  assign rd_out        = head_q.rd;
  assign reg_write_out = head_q.rw & out_valid;

  // Buffer next-state: flush empties without touching head data.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            head_d  = new_entry;
            state_d = StOne;
          end
        end
        StOne: begin
          if (push && pop) begin
            head_d = new_entry;
          end else if (push) begin
            skid_d  = new_entry;
            state_d = StFull;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // State and entry registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_wb_result_stage.sv
module tb_wb_result_stage;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic         in_ready, out_valid, reg_write_out;
  logic [127:0] src_data;
  logic [1:0]   result_src, addr_lsb;
  logic [2:0]   funct3;
  logic [4:0]   rd_in, rd_out;
  logic         reg_write_in;
  logic [31:0]  result;

  // Second instance with three sources to exercise the out-of-range select.
  logic         in_valid3, in_ready3, out_valid3, reg_write_out3;
  logic [31:0]  result3;
  logic [4:0]   rd_out3;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t q[$];
  exp_t cur_exp;
  int   errors = 0;
  int   checks = 0;
  int   pushes = 0;

  always #5 clk = ~clk;

  wb_result_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .src_data(src_data), .result_src(result_src), .funct3(funct3), .addr_lsb(addr_lsb),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .rd_out(rd_out), .reg_write_out(reg_write_out)
  );

  wb_result_stage #(.NUM_SRC(3)) dut3 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid3), .in_ready(in_ready3),
    .src_data(src_data[95:0]), .result_src(result_src), .funct3(funct3),
    .addr_lsb(addr_lsb), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .out_valid(out_valid3), .out_ready(1'b1), .result(result3), .rd_out(rd_out3),
    .reg_write_out(reg_write_out3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head is compared with the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      exp_t e;
      if (q.size() == 0) begin
        check("unexpected_pop", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("mon_result", result, e.res);
        check("mon_rd", {27'd0, rd_out}, {27'd0, e.rd});
        check("mon_rw", {31'd0, reg_write_out}, {31'd0, e.rw});
      end
    end
  end

  // One clock: record the push (or flush) at negedge, return at posedge+1.
  task automatic step();
    @(negedge clk);
    if (flush) q.delete();
    else if (in_valid && in_ready) begin
      q.push_back(cur_exp);
      pushes++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] lsb,
                       input logic [4:0] rd, input logic rw, input logic [31:0] exp_res);
    in_valid     = 1'b1;
    result_src   = sel;
    funct3       = f3;
    addr_lsb     = lsb;
    rd_in        = rd;
    reg_write_in = rw;
    cur_exp      = '{res: exp_res, rd: rd, rw: rw};
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("drained", q.size(), 32'd0);
  endtask

  logic [31:0] ld_exp [6];
  logic [2:0]  ld_f3  [6];
  logic [1:0]  ld_lsb [6];

  initial begin
    ld_f3[0] = 3'b000; ld_lsb[0] = 2'd0; ld_exp[0] = 32'hFFFFFF85;
    ld_f3[1] = 3'b100; ld_lsb[1] = 2'd3; ld_exp[1] = 32'h00000080;
    ld_f3[2] = 3'b001; ld_lsb[2] = 2'd2; ld_exp[2] = 32'hFFFF80F1;
    ld_f3[3] = 3'b101; ld_lsb[3] = 2'd0; ld_exp[3] = 32'h00007F85;
    ld_f3[4] = 3'b010; ld_lsb[4] = 2'd1; ld_exp[4] = 32'h80F17F85;
    ld_f3[5] = 3'b011; ld_lsb[5] = 2'd2; ld_exp[5] = 32'h80F17F85;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid3 = 1'b0; out_ready = 1'b0;
    src_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    result_src = '0; funct3 = '0; addr_lsb = '0; rd_in = '0; reg_write_in = 1'b0;
    cur_exp = '0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Source select, back-to-back with out_ready high.
    out_ready = 1'b1;
    drive(2'd0, 3'b010, 2'd0, 5'd1, 1'b1, 32'h11111111); step();
    drive(2'd1, 3'b010, 2'd0, 5'd2, 1'b1, 32'h22222222); step();
    drive(2'd2, 3'b010, 2'd0, 5'd3, 1'b0, 32'h33333333); step();
    drive(2'd3, 3'b010, 2'd0, 5'd0, 1'b1, 32'h44444444); step();
    drain();

    // Out-of-range select on the three-source instance.
    in_valid3 = 1'b1; result_src = 2'd3; step();
    in_valid3 = 1'b0;
    check("sel3_valid", {31'd0, out_valid3}, 32'd1);
    check("sel3_zero", result3, 32'd0);
    in_valid3 = 1'b1; result_src = 2'd2; step();
    in_valid3 = 1'b0;
    check("sel3_src2", result3, 32'h33333333);

    // Load extension.
    src_data[63:32] = 32'h80F17F85;
    for (int i = 0; i < 6; i++) begin
      drive(2'd1, ld_f3[i], ld_lsb[i], 5'(i + 4), 1'b1, ld_exp[i]);
      step();
    end
    drain();

    // Backpressure: A then B fill the buffer, head holds A.
    out_ready = 1'b0;
    drive(2'd0, 3'b000, 2'd0, 5'd10, 1'b1, 32'h11111111); src_data[31:0] = 32'hAAAA0001;
    cur_exp.res = 32'hAAAA0001; step();
    drive(2'd0, 3'b000, 2'd0, 5'd11, 1'b1, 32'hBBBB0002); src_data[31:0] = 32'hBBBB0002;
    step();
    in_valid = 1'b0;
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_head_a", result, 32'hAAAA0001);
    step();
    check("bp_hold_a", result, 32'hAAAA0001);
    check("bp_hold_rd", {27'd0, rd_out}, 32'd10);
    out_ready = 1'b1; step();
    check("bp_head_b", result, 32'hBBBB0002);
    check("bp_ready_again", {31'd0, in_ready}, 32'd1);
    step();
    check("bp_empty", {31'd0, out_valid}, 32'd0);
    check("bp_rw_gated", {31'd0, reg_write_out}, 32'd0);

    // Simultaneous push and pop while holding one entry.
    out_ready = 1'b0;
    src_data[31:0] = 32'hC0C0C0C0; drive(2'd0, 3'b000, 2'd0, 5'd12, 1'b0, 32'hC0C0C0C0); step();
    src_data[31:0] = 32'hD0D0D0D0; drive(2'd0, 3'b000, 2'd0, 5'd13, 1'b1, 32'hD0D0D0D0);
    out_ready = 1'b1; step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("pp_head_b", result, 32'hD0D0D0D0);
    check("pp_in_ready", {31'd0, in_ready}, 32'd1);
    check("pp_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // Flush on a full buffer with a concurrent push attempt.
    out_ready = 1'b0;
    src_data[31:0] = 32'hE1E1E1E1; drive(2'd0, 3'b000, 2'd0, 5'd14, 1'b1, 32'hE1E1E1E1); step();
    src_data[31:0] = 32'hE2E2E2E2; drive(2'd0, 3'b000, 2'd0, 5'd15, 1'b1, 32'hE2E2E2E2); step();
    src_data[31:0] = 32'hE3E3E3E3; drive(2'd0, 3'b000, 2'd0, 5'd16, 1'b1, 32'hE3E3E3E3);
    flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_rw", {31'd0, reg_write_out}, 32'd0);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    check("fl_result_hold", result, 32'hE1E1E1E1);
    // Flush in ONE state, where the push would otherwise be accepted.
    drive(2'd0, 3'b000, 2'd0, 5'd17, 1'b1, 32'hE3E3E3E3); step();
    src_data[31:0] = 32'hE4E4E4E4; drive(2'd0, 3'b000, 2'd0, 5'd18, 1'b1, 32'hE4E4E4E4);
    flush = 1'b1; step();
    flush = 1'b0;
    check("fl1_out_valid", {31'd0, out_valid}, 32'd0);
    drain();

    // Random valid/ready stream against the scoreboard.
    begin
      int cyc;
      cyc = 0;
      pushes = 0;
      while (pushes < 1000 && cyc < 8000) begin
        src_data[31:0] = $urandom;
        drive(2'd0, 3'b010, 2'd0, 5'($urandom), 1'($urandom), src_data[31:0]);
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        step();
        cyc++;
      end
      check("rand_count", pushes, 32'd1000);
      drain();
    end

    // Asynchronous reset with a full buffer.
    out_ready = 1'b0;
    src_data[31:0] = 32'h5A5A5A5A; drive(2'd0, 3'b000, 2'd0, 5'd20, 1'b1, 32'h5A5A5A5A); step();
    drive(2'd0, 3'b000, 2'd0, 5'd21, 1'b1, 32'h5A5A5A5A); step();
    in_valid = 1'b0;
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    q.delete();
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_rw", {31'd0, reg_write_out}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
